// File: rtl/serial_adder_pkg.sv
// Purpose : shared constants for the bit-serial adder (state encoding, default width).
// Latency : n/a (declarations only).
// Backpressure: n/a.
package serial_adder_pkg;

  // Controller state encoding; kept as plain 2-bit constants for compatibility
  // with older blocks that decode the state bus directly.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Default operand/result width.
  localparam int SA_N_DEFAULT = 8;

endpackage

// File: rtl/serial_adder_fa.sv
// Purpose : 1-bit full adder cell, the single arithmetic element of the serial adder.
// Latency : combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   a, b : operand bits
//   ci   : carry in
//   sum  : a ^ b ^ ci
//   co   : carry out (majority of a, b, ci)
module serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic co
);

  logic p;

  assign p   = a ^ b;
  assign sum = p ^ ci;
  assign co  = (a & b) | (ci & p);

endmodule

// File: rtl/serial_adder.sv
// Purpose : bit-serial N-bit adder, one FA cell fed LSB first, carry recirculated through a flop.
// Latency : sum/cout update N edges after the accepting edge; done pulses the following cycle; N+2 cycles per op.
// Backpressure: no handshake; start is only honoured in IDLE and is silently dropped while busy or done.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   start : request an addition (sampled only in IDLE)
//   a, b  : operands, captured on the accepting edge
//   cin   : carry in, captured on the accepting edge
//   busy  : high while bits are being processed
//   done  : one-cycle pulse when sum/cout carry a fresh result
//   sum   : registered result word, held until the next completion
//   cout  : registered carry out of bit N-1, held with sum
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int N = SA_N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [1:0]    state;
  logic [N-1:0]  sh_a;
  logic [N-1:0]  sh_b;
  // Only the upper N-1 partial-sum bits are ever needed: the bit that would
  // sit in position 0 is shifted out on the same edge the word completes.
  logic [N-2:0]  sh_s;
  logic          carry;
  logic [CW-1:0] cnt;

  logic          fa_sum;
  logic          fa_co;
  logic [N-1:0]  sh_s_next;

  serial_adder_fa u_fa (
    .a   (sh_a[0]),
    .b   (sh_b[0]),
    .ci  (carry),
    .sum (fa_sum),
    .co  (fa_co)
  );

  // New sum bit enters at the MSB; after N shifts bit 0 holds the LSB result.
  assign sh_s_next = {fa_sum, sh_s};

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sh_a  <= '0;
      sh_b  <= '0;
      sh_s  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sh_a  <= a;
            sh_b  <= b;
            carry <= cin;
            cnt   <= '0;
            sh_s  <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          carry <= fa_co;
          sh_s  <= sh_s_next[N-1:1];
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          if (cnt == CNT_LAST) begin
            // Last bit: publish the word; counter parks at 0 instead of wrapping.
            cnt   <= '0;
            sum   <= sh_s_next;
            cout  <= fa_co;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around one instance of the team's existing 1-bit full adder (FA).
- It is the sequential stage that feeds the FA one operand bit pair per clock, LSB first.
- It registers the FA carry-out back into the FA carry-in, and collects the FA sum bits into a result word.
- It sits between the board switch/operand registers and the display logic, trading N cycles of latency for a single FA cell.

Parameters:
- N, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk    input   1   system clock, rising-edge active
- rst_n  input   1   synchronous, active-low reset (sampled on rising clk)
- start  input   1   request an addition; sampled only in IDLE
- a      input   N   operand A, sampled on the accepting edge only
- b      input   N   operand B, sampled on the accepting edge only
- cin    input   1   carry-in, sampled on the accepting edge only
- busy   output  1   high while an addition is in progress (RUN state)
- done   output  1   one-cycle pulse: sum/cout hold a new result
- sum    output  N   result word, registered, held until next completion
- cout   output  1   final carry-out, registered, held with sum

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n). While rst_n=0 at a rising edge, the next state is:
  - state=IDLE, busy=0, done=0, sum=0, cout=0;
  - internal shift registers and carry flop cleared, bit counter=0.
- States:
  - IDLE: busy=0, done=0. If start=1 at an edge, the block loads:
    - shA<=a, shB<=b, carry<=cin, cnt<=0, shS<=0;
    - goes to RUN.
    - start=0 stays in IDLE.
  - RUN: busy=1, done=0. The FA inputs are shA[0], shB[0], carry. Each edge:
    - carry<=FA.co;
    - shS<={FA.sum, shS[N-1:1]};
    - shA>>1, shB>>1;
    - cnt<=cnt+1.
    - On the edge where cnt==N-1 (the N-th bit is processed), go to DONE and load:
      - sum<={FA.sum, shS[N-1:1]};
      - cout<=FA.co.
  - DONE: busy=0, done=1 for exactly one cycle. The next edge always returns to IDLE; start is ignored in DONE.
- Latency: let E0 be the edge that samples start.
  - sum/cout update at edge E_N.
  - done is high during the cycle between E_N and E_N+1.
  - The earliest next accepted start is at edge E_N+2 (total throughput N+2 cycles per operation).
- Ignored inputs:
  - start while busy=1 or done=1 is ignored.
  - a/b/cin changes after E0 have no effect on the in-flight result.
- Outputs sum and cout keep the previous result throughout RUN. They change only at completion or reset.
- Arithmetic: {cout,sum} == a + b + cin exactly, computed modulo 2^(N+1). No overflow flag; cout is the carry out of bit N-1.
- Counter width is clog2(N); it never wraps past N-1 within one operation.
- Reset mid-operation (rst_n=0 during RUN or DONE):
  - aborts immediately at that edge;
  - no done pulse is produced;
  - sum/cout are cleared to 0;
  - start is not accepted on the reset edge.
- Simultaneous rst_n=0 and start=1: reset wins.

Decomposition:
- Shared package/header holds:
  - the state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - the default width constant for N.
- One sub-module, the existing FA cell (ports a, b, ci, sum, co), instantiated once. All sequencing, shift registers and the carry flop live in serial_adder.

Test Plan:
- Exhaustive sweep, N=4: all 512 (a,b,cin) combinations, start pulsed from IDLE -> for each, done rises after the 4th edge following the start edge, {cout,sum}==a+b+cin, and busy is high for exactly 4 cycles.
- Carry ripple, N=8: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Start while busy, N=8: a=8'h12, b=8'h34 accepted; 3 cycles later start=1 with a=8'hAA, b=8'h55 -> ignored, result sum=8'h46, cout=0, single done pulse.
- Input stability, N=8: a=8'h0F, b=8'hF0, cin=1 accepted; change a/b every cycle during RUN -> sum=8'h00, cout=1.
- Reset mid-run, N=8: after a completed 8'h10+8'h20 (sum=8'h30), start 8'h7F+8'h01 and assert rst_n=0 at the 4th RUN edge -> sum=0, cout=0, busy=0, no done pulse. start asserted the cycle after release is accepted normally.
- Back-to-back, N=8: start held high continuously with fixed operands 8'h05+8'h03 -> done pulses every N+2=10 cycles, sum=8'h08 each time; sum is held stable between pulses.
